// File: rtl/div_double_pkg.sv
// Shared field widths, IEEE-754 double constants, FSM states and flag indices
// for the sequential double-precision divider.
package div_double_pkg;

    localparam int unsigned EXP_W  = 11;
    localparam int unsigned MANT_W = 52;
    localparam int unsigned FRAC_W = MANT_W + 1;
    localparam int unsigned QUOT_W = MANT_W + 2;
    localparam int unsigned REM_W  = MANT_W + 3;
    localparam int unsigned SEXP_W = 13;

    localparam int unsigned DBL_EXP_BIAS     = 1023;
    localparam logic [63:0] DBL_QNAN         = 64'h7FF8000000000000;
    localparam logic [EXP_W-1:0] DBL_EXP_MAX = 11'h7FF;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        NORM
    } state_t;

    localparam int unsigned FLAG_W         = 5;
    localparam int unsigned FLAG_INVALID   = 4;
    localparam int unsigned FLAG_DIVZERO   = 3;
    localparam int unsigned FLAG_OVERFLOW  = 2;
    localparam int unsigned FLAG_UNDERFLOW = 1;
    localparam int unsigned FLAG_INEXACT   = 0;

endpackage

// File: rtl/div_double_seq_mant_div_iter.sv
// Restoring mantissa divider: Q = floor(fa * 2^53 / fb), resolving
// BITS_PER_CYCLE quotient bits per step.
module mant_div_iter
    import div_double_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [FRAC_W-1:0] dividend,
    input  logic [FRAC_W-1:0] divisor,
    output logic [QUOT_W-1:0] quot,
    output logic              rem_nz_c
);

    logic [REM_W-1:0]  rem_q;
    logic [FRAC_W-1:0] dsr_q;
    logic [REM_W-1:0]  rem_nxt;
    logic [QUOT_W-1:0] quot_nxt;

    // Compare/subtract/shift chain; remainder stays below 2*divisor
    always_comb begin
        rem_nxt  = rem_q;
        quot_nxt = quot;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (rem_nxt >= {2'b00, dsr_q}) begin
                rem_nxt  = rem_nxt - {2'b00, dsr_q};
                quot_nxt = {quot_nxt[QUOT_W-2:0], 1'b1};
            end else begin
                quot_nxt = {quot_nxt[QUOT_W-2:0], 1'b0};
            end
            rem_nxt = {rem_nxt[REM_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q <= '0;
            dsr_q <= '0;
            quot  <= '0;
        end else if (load) begin
            rem_q <= {2'b00, dividend};
            dsr_q <= divisor;
            quot  <= '0;
        end else if (step) begin
            rem_q <= rem_nxt;
            quot  <= quot_nxt;
        end
    end

    assign rem_nz_c = |rem_q;

endmodule

// File: rtl/div_double_seq.sv
// Iterative IEEE-754 double divider (FTZ, truncating) with start/done handshake.
// Define DIV_DOUBLE_FLAGS_EN to add the flags[4:0] exception output.
module div_double_seq
    import div_double_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] result
`ifdef DIV_DOUBLE_FLAGS_EN
    ,
    output logic [FLAG_W-1:0] flags
`endif
);

    localparam int unsigned ITERS = QUOT_W / BITS_PER_CYCLE;
    localparam int unsigned CNT_W = 6;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               sign_q;
    logic               spec_q;
    logic [63:0]        spec_res_q;
    logic [EXP_W-1:0]   exp_a_q;
    logic [EXP_W-1:0]   exp_b_q;

    logic [EXP_W-1:0]   ea, eb;
    logic [MANT_W-1:0]  ma, mb;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_c;
    logic               spec_c;
    logic [63:0]        spec_res_c;

    logic [QUOT_W-1:0]  quot;
    logic               rem_nz_c;
    logic               load_c;

    logic signed [SEXP_W-1:0] exp_a_s, exp_b_s, bias_c, exp_c;
    logic [MANT_W-1:0]  mant_c;
    logic [63:0]        pack_res_c;

`ifdef DIV_DOUBLE_FLAGS_EN
    logic [FLAG_W-1:0]  spec_flags_c, spec_flags_q, pack_flags_c;
`else
    logic               unused_rem_nz;
    assign unused_rem_nz = rem_nz_c;
`endif

    assign ea     = a[62:52];
    assign eb     = b[62:52];
    assign ma     = a[51:0];
    assign mb     = b[51:0];
    assign sign_c = a[63] ^ b[63];
    // Exponent zero covers subnormals, which are flushed to zero
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == DBL_EXP_MAX) && (ma == '0);
    assign b_inf  = (eb == DBL_EXP_MAX) && (mb == '0);
    assign a_nan  = (ea == DBL_EXP_MAX) && (ma != '0);
    assign b_nan  = (eb == DBL_EXP_MAX) && (mb != '0);

    // Special-case classification in priority order
    always_comb begin
        spec_c     = 1'b1;
        spec_res_c = DBL_QNAN;
`ifdef DIV_DOUBLE_FLAGS_EN
        spec_flags_c = '0;
`endif
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_res_c = DBL_QNAN;
`ifdef DIV_DOUBLE_FLAGS_EN
            spec_flags_c[FLAG_INVALID] = 1'b1;
`endif
        end else if (a_inf || b_zero) begin
            spec_res_c = {sign_c, DBL_EXP_MAX, MANT_W'(0)};
`ifdef DIV_DOUBLE_FLAGS_EN
            spec_flags_c[FLAG_DIVZERO] = b_zero && !a_inf;
`endif
        end else if (a_zero || b_inf) begin
            spec_res_c = {sign_c, 63'd0};
        end else begin
            spec_c = 1'b0;
        end
    end

    assign load_c = (state == IDLE) && start && !spec_c;

    mant_div_iter #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_mant_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_c),
        .step     (state == DIV),
        .dividend ({1'b1, ma}),
        .divisor  ({1'b1, mb}),
        .quot     (quot),
        .rem_nz_c (rem_nz_c)
    );

    assign exp_a_s = {2'b00, exp_a_q};
    assign exp_b_s = {2'b00, exp_b_q};
    assign bias_c  = quot[QUOT_W-1] ? SEXP_W'(DBL_EXP_BIAS) : SEXP_W'(DBL_EXP_BIAS - 1);

    // Normalise the quotient and pack with range clamping
    always_comb begin
        mant_c     = quot[QUOT_W-1] ? quot[QUOT_W-2:1] : quot[MANT_W-1:0];
        exp_c      = exp_a_s - exp_b_s + bias_c;
        pack_res_c = {sign_q, exp_c[EXP_W-1:0], mant_c};
`ifdef DIV_DOUBLE_FLAGS_EN
        pack_flags_c = '0;
        pack_flags_c[FLAG_INEXACT] = rem_nz_c || (quot[QUOT_W-1] && quot[0]);
`endif
        if (exp_c >= 13'sd2047) begin
            pack_res_c = {sign_q, DBL_EXP_MAX, MANT_W'(0)};
`ifdef DIV_DOUBLE_FLAGS_EN
            pack_flags_c[FLAG_OVERFLOW] = 1'b1;
            pack_flags_c[FLAG_INEXACT]  = 1'b1;
`endif
        end else if (exp_c <= 13'sd0) begin
            pack_res_c = {sign_q, 63'd0};
`ifdef DIV_DOUBLE_FLAGS_EN
            pack_flags_c[FLAG_UNDERFLOW] = 1'b1;
            pack_flags_c[FLAG_INEXACT]   = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            cnt        <= '0;
            sign_q     <= 1'b0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            exp_a_q    <= '0;
            exp_b_q    <= '0;
`ifdef DIV_DOUBLE_FLAGS_EN
            spec_flags_q <= '0;
            flags        <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy       <= 1'b1;
                        sign_q     <= sign_c;
                        spec_q     <= spec_c;
                        spec_res_q <= spec_res_c;
                        exp_a_q    <= ea;
                        exp_b_q    <= eb;
`ifdef DIV_DOUBLE_FLAGS_EN
                        spec_flags_q <= spec_flags_c;
`endif
                        state      <= spec_c ? NORM : DIV;
                    end
                end
                DIV: begin
                    if (cnt == CNT_W'(ITERS - 1)) begin
                        cnt   <= '0;
                        state <= NORM;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                NORM: begin
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    result <= spec_q ? spec_res_q : pack_res_c;
`ifdef DIV_DOUBLE_FLAGS_EN
                    flags  <= spec_q ? spec_flags_q : pack_flags_c;
`endif
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_double_seq.sv
// Directed scoreboard bench for div_double_seq: values, latency, handshake, reset.
module tb_div_double_seq;

    localparam int LAT_N = 55;
    localparam int LAT_S = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        busy;
    logic        done;
    logic [63:0] result;
`ifdef DIV_DOUBLE_FLAGS_EN
    logic [4:0]  flags;
`endif

    div_double_seq #(.BITS_PER_CYCLE(1)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
`ifdef DIV_DOUBLE_FLAGS_EN
        ,
        .flags  (flags)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Called #1 after an edge with the DUT idle; returns #1 after the accepting edge
    task automatic launch(input logic [63:0] ta, input logic [63:0] tbv,
                          input logic [63:0] er, input int el, input string tag);
        exp_t e;
        e.res = er;
        e.lat = el;
        e.tag = tag;
        sb_q.push_back(e);
        a     = ta;
        b     = tbv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits (bounded) for done; optionally re-pulses start at edge 'poke'
    task automatic wait_result(input int poke);
        int   edges = 0;
        bit   busy_ok = 1'b1;
        exp_t e;
        while (edges < 200) begin
            @(posedge clk);
            edges++;
            #1;
            if (done === 1'b1) break;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (edges == poke) begin
                a     = 64'h3FF0000000000000;
                b     = 64'h4008000000000000;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        e = sb_q.pop_front();
        check({e.tag, "_done"},         64'(done),    64'd1);
        check({e.tag, "_latency"},      64'(edges),   64'(e.lat));
        check({e.tag, "_result"},       result,       e.res);
        check({e.tag, "_busy_run"},     64'(busy_ok), 64'd1);
        check({e.tag, "_busy_at_done"}, 64'(busy),    64'd0);
    endtask

    initial begin
        bit extra_done;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   64'(busy), 64'd0);
        check("reset_done",   64'(done), 64'd0);
        check("reset_result", result,    64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 6/2 with a second start pulse mid-division that must be ignored
        launch(64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, LAT_N, "six_by_two");
        wait_result(10);
`ifdef DIV_DOUBLE_FLAGS_EN
        check("six_by_two_flags", 64'(flags), 64'd0);
`endif
        extra_done = 1'b0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) extra_done = 1'b1;
        end
        check("ignored_start_no_done", 64'(extra_done), 64'd0);
        check("ignored_start_result",  result,          64'h4008000000000000);

        launch(64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, LAT_N, "one_by_three");
        wait_result(-1);
`ifdef DIV_DOUBLE_FLAGS_EN
        check("one_by_three_inexact", 64'(flags[0]), 64'd1);
`endif

        // Specials and range cases, each launched back-to-back in the done cycle
        launch(64'h3FF0000000000000, 64'h0000000000000000, 64'h7FF0000000000000, LAT_S, "one_by_zero");
        wait_result(-1);
`ifdef DIV_DOUBLE_FLAGS_EN
        check("one_by_zero_flags", 64'(flags), 64'h08);
`endif
        launch(64'hBFF0000000000000, 64'h0000000000000000, 64'hFFF0000000000000, LAT_S, "neg_one_by_zero");
        wait_result(-1);
        launch(64'h0000000000000000, 64'h0000000000000000, 64'h7FF8000000000000, LAT_S, "zero_by_zero");
        wait_result(-1);
        launch(64'h7FF0000000000000, 64'h7FF0000000000000, 64'h7FF8000000000000, LAT_S, "inf_by_inf");
        wait_result(-1);
        launch(64'h7FF4000000000000, 64'h3FF0000000000000, 64'h7FF8000000000000, LAT_S, "snan_by_one");
        wait_result(-1);
        launch(64'h7FEFFFFFFFFFFFFF, 64'h3CB0000000000000, 64'h7FF0000000000000, LAT_N, "overflow");
        wait_result(-1);
        launch(64'h0010000000000000, 64'h4000000000000000, 64'h0000000000000000, LAT_N, "underflow");
        wait_result(-1);
        launch(64'h4018000000000000, 64'h4000000000000000, 64'h4008000000000000, LAT_N, "b2b_six_by_two");
        wait_result(-1);

        // Abort a division with reset at cycle 20
        launch(64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, LAT_N, "aborted");
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_busy",   64'(busy), 64'd0);
        check("midreset_done",   64'(done), 64'd0);
        check("midreset_result", result,    64'd0);
        rst_n = 1'b1;
        void'(sb_q.pop_back());

        launch(64'h3FF0000000000000, 64'h4008000000000000, 64'h3FD5555555555555, LAT_N, "after_reset");
        wait_result(-1);

        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
